// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
// Segment bit order is a..g on bits 6..0; glyphs are active-high patterns.
package seg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        BLANK,
        ACTIVE
    } scan_state_t;

    localparam seg_t SEG_OFF = 7'b0000000;
    localparam seg_t SEG_ALL = 7'b1111111;

    localparam seg_t GLYPH_D = 7'b0111101;
    localparam seg_t GLYPH_E = 7'b1001111;
    localparam seg_t GLYPH_A = 7'b1110111;

    // Active-low anode pattern with only the given digit enabled.
    function automatic logic [3:0] anode_select(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/seg_scan_driver_scan_timer.sv
// Loadable down-counter; tc is high while the count is zero.
// Load wins over counting, and the count holds at zero until reloaded.
module scan_timer #(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VALUE;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes four latched segment patterns onto an active-low 4-digit display,
// with a blank gap between digits and frame-synchronous blinking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned ON_CYCLES    = 100000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  seg_t       seg_in [3:0],
    input  logic [3:0] digit_mask,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int unsigned MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned BLINK_W    = $clog2(BLINK_FRAMES + 1);

    // Timer counts down to zero, so each state is loaded with its length minus one.
    localparam logic [CNT_W-1:0]   ON_LOAD    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    scan_state_t        state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    seg_t               shadow_q [3:0];
    seg_t               shadow_d [3:0];
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_on_q, phase_on_d;
    logic [3:0]         an_q, an_d;
    seg_t               seg_q, seg_d;
    logic               frame_start_q, frame_start_d;
    logic               dp_q;

    logic               timer_tc;
    logic               timer_load;
    logic [CNT_W-1:0]   timer_value;
    logic               snap;

    scan_timer #(
        .WIDTH       (CNT_W),
        .RESET_VALUE (BLANK_LOAD)
    ) u_scan_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        blink_cnt_d   = blink_cnt_q;
        phase_on_d    = phase_on_q;
        snap          = 1'b0;
        timer_load    = timer_tc;
        timer_value   = (state_q == BLANK) ? ON_LOAD : BLANK_LOAD;
        an_d          = 4'b1111;
        seg_d         = ~SEG_OFF;

        if (timer_tc) begin
            if (state_q == BLANK) begin
                state_d = ACTIVE;
                snap    = (idx_q == 2'd0);
            end else begin
                state_d = BLANK;
                idx_d   = idx_q + 2'd1;
            end
        end

        if (snap) begin
            shadow_d = seg_in;
        end

        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_on_d  = 1'b1;
        end else if (snap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_on_d  = ~phase_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end

        // Outputs are decoded from next-state values so they register in step with the FSM.
        if (state_d == ACTIVE) begin
            seg_d = ~shadow_d[idx_d];
            if (digit_mask[idx_d] && phase_on_d) begin
                an_d = anode_select(idx_d);
            end
        end

        frame_start_d = snap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BLANK;
            idx_q         <= 2'd0;
            shadow_q      <= '{default: SEG_OFF};
            blink_cnt_q   <= '0;
            phase_on_q    <= 1'b1;
            an_q          <= 4'b1111;
            seg_q         <= ~SEG_OFF;
            frame_start_q <= 1'b0;
            dp_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_on_q    <= phase_on_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
            dp_q          <= 1'b1;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-position model predicts each cycle's outputs,
// and a negedge monitor watches anode exclusivity and inter-digit blank gaps.
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int ON    = 4;
    localparam int BLK   = 2;
    localparam int SLOT  = ON + BLK;
    localparam int FRAME = 4 * SLOT;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    seg_t       seg_in [3:0];
    logic [3:0] digit_mask;
    logic       blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    int   m_k;
    int   m_p;
    int   bl_frames;
    logic m_lit;
    seg_t frame_pat [3:0];

    logic [3:0] last_lit = 4'hF;
    int         blank_run = 0;

    seg_scan_driver #(
        .ON_CYCLES    (ON),
        .BLANK_CYCLES (BLK),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .digit_mask  (digit_mask),
        .blink_en    (blink_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict outputs after the next edge from position in the frame, then compare.
    task automatic step();
        exp_t e;
        int   slot;
        int   off;
        m_k++;
        if (!blink_en) bl_frames = 0;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.fs  = 1'b0;
        m_lit = 1'b1;
        m_p   = -1;
        if (m_k >= BLK) begin
            m_p  = (m_k - BLK) % FRAME;
            slot = m_p / SLOT;
            off  = m_p % SLOT;
            if (m_p == 0) begin
                frame_pat = seg_in;
                e.fs      = 1'b1;
                if (blink_en) bl_frames++;
            end
            m_lit = !blink_en || ((bl_frames / 2) % 2 == 0);
            if (off < ON) begin
                e.seg = ~frame_pat[slot];
                if (m_lit && digit_mask[slot]) e.an = ~(4'b0001 << slot);
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("an", 32'(an), 32'(e.an));
        check("seg", 32'(seg), 32'(e.seg));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("dp", 32'(dp), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset(input int hold);
        reset = 1'b1;
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_dp", 32'(dp), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_an", 32'(an), 32'hF);
        end
        reset     = 1'b0;
        m_k       = 0;
        bl_frames = 0;
    endtask

    always @(negedge clk) begin
        if (an == 4'hF) begin
            blank_run++;
        end else begin
            check("one_low", 32'($countones(~an)), 32'd1);
            if (last_lit != 4'hF && an != last_lit) check("gap", 32'(blank_run >= BLK), 32'd1);
            blank_run = 0;
            last_lit  = an;
        end
    end

    initial begin
        bit found;
        seg_in     = '{default: SEG_OFF};
        digit_mask = 4'b1111;
        blink_en   = 1'b0;
        #2;
        seg_in[3] = GLYPH_D;
        seg_in[2] = GLYPH_E;
        seg_in[1] = GLYPH_A;
        seg_in[0] = GLYPH_D;
        apply_reset(3);
        run(BLK + 2 * FRAME);

        // Change digit 2's input while digit 1 is lit; it must wait for the next frame.
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            if (m_p == SLOT + 1) found = 1;
        end
        check("find_slot1", 32'(found), 32'd1);
        seg_in[2] = SEG_ALL;
        run(2 * FRAME);

        seg_in   = '{default: SEG_ALL};
        blink_en = 1'b1;
        run(5 * FRAME);
        found = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            step();
            if (!m_lit && m_p == SLOT + 1) found = 1;
        end
        check("find_dark", 32'(found), 32'd1);
        blink_en = 1'b0;
        step();
        check("blink_drop_an", 32'(an), 32'hD);
        run(FRAME);

        digit_mask = 4'b0101;
        run(2 * FRAME);
        digit_mask = 4'b1111;

        // Reset while digit 2 is active, then the scan must restart at digit 0.
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            if (m_p == 2 * SLOT + 1) found = 1;
        end
        check("find_slot2", 32'(found), 32'd1);
        check("slot2_lit", 32'(an), 32'hB);
        apply_reset(2);
        run(BLK + FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
